module_banco_registros_clr: RTL and testbench

//  Parametrised 2^N x DATA_WIDTH register bank: two combinational read ports, one write port.

---
 rtl/module_banco_registros_clr.sv | 122 ++++++++++++
 tb/tb_module_banco_registros_clr.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/module_banco_registros_clr.sv
// rtl/module_banco_registros_clr.sv - register bank with zero register, write bypass and sequential clear engine
module module_banco_registros_clr #(
  parameter int N          = 2,
  parameter int DATA_WIDTH = 4,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  we_i,
  input  logic                  clr_i,
  input  logic [N-1:0]          addr_rs1_i,
  input  logic [N-1:0]          addr_rs2_i,
  input  logic [N-1:0]          addr_rd_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] rs1_o,
  output logic [DATA_WIDTH-1:0] rs2_o,
  output logic                  busy_o,
  output logic                  clr_done_o,
  output logic                  wr_drop_o
);

  localparam int DEPTH = 1 << N;
  localparam logic [N-1:0] LAST_IDX = {N{1'b1}};

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [N-1:0]          r_cnt;
  logic [N-1:0]          w_cnt_next;
  logic [DATA_WIDTH-1:0] r_bank [DEPTH];
  logic                  r_wr_drop;
  logic                  w_busy;
  logic                  w_rd_is_zero;
  logic                  w_wr_acc;
  logic                  w_wr_drop;

  assign w_busy       = (r_state == S_CLEAR);
  assign w_rd_is_zero = (ZERO_REG != 0) && (addr_rd_i == '0);
  // clr_i in the same cycle as a write wins: the write would otherwise be wiped anyway
  assign w_wr_acc     = we_i & ~w_busy & ~clr_i & ~w_rd_is_zero;
  assign w_wr_drop    = we_i & (w_busy | clr_i);

  assign busy_o     = w_busy;
  assign clr_done_o = w_busy && (r_cnt == LAST_IDX);
  assign wr_drop_o  = r_wr_drop;

  // FSM state, clear counter and drop flag registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_wr_drop <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_wr_drop <= w_wr_drop;
    end
  end

  // Next-state logic: clr_i only starts a clear from IDLE, so it cannot restart one
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (clr_i) begin
          w_state_next = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (r_cnt == LAST_IDX) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Register storage: clear engine wipes one entry per cycle, otherwise accepted writes land
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_bank[i] <= '0;
      end
    end else if (w_busy) begin
      r_bank[r_cnt] <= '0;
    end else if (w_wr_acc) begin
      r_bank[addr_rd_i] <= data_i;
    end
  end

  // Read port 1: zero register overrides the bypass path
  always_comb begin
    rs1_o = r_bank[addr_rs1_i];
    if ((BYPASS != 0) && w_wr_acc && (addr_rd_i == addr_rs1_i)) begin
      rs1_o = data_i;
    end
    if ((ZERO_REG != 0) && (addr_rs1_i == '0)) begin
      rs1_o = '0;
    end
  end

  // Read port 2: identical selection to port 1
  always_comb begin
    rs2_o = r_bank[addr_rs2_i];
    if ((BYPASS != 0) && w_wr_acc && (addr_rd_i == addr_rs2_i)) begin
      rs2_o = data_i;
    end
    if ((ZERO_REG != 0) && (addr_rs2_i == '0)) begin
      rs2_o = '0;
    end
  end

endmodule

// File: tb/tb_module_banco_registros_clr.sv
// tb/tb_module_banco_registros_clr.sv - scoreboard bench for two configurations of the register bank
`timescale 1ns/1ps
module tb_module_banco_registros_clr;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       we = 1'b0;
  logic       clr = 1'b0;
  logic [1:0] a1 = '0;
  logic [1:0] a2 = '0;
  logic [1:0] rd = '0;
  logic [3:0] din = '0;

  logic [3:0] rs1_a, rs2_a, rs1_b, rs2_b;
  logic       busy_a, done_a, drop_a, busy_b, done_b, drop_b;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  logic [3:0][3:0] m_a;
  logic [3:0][3:0] m_b;
  logic            m_busy;
  logic [1:0]      m_cnt;
  logic            m_drop;

  always #50 clk = ~clk;

  module_banco_registros_clr #(.N(2), .DATA_WIDTH(4), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .we_i(we), .clr_i(clr),
    .addr_rs1_i(a1), .addr_rs2_i(a2), .addr_rd_i(rd), .data_i(din),
    .rs1_o(rs1_a), .rs2_o(rs2_a), .busy_o(busy_a), .clr_done_o(done_a), .wr_drop_o(drop_a)
  );

  module_banco_registros_clr #(.N(2), .DATA_WIDTH(4), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .we_i(we), .clr_i(clr),
    .addr_rs1_i(a1), .addr_rs2_i(a2), .addr_rd_i(rd), .data_i(din),
    .rs1_o(rs1_b), .rs2_o(rs2_b), .busy_o(busy_b), .clr_done_o(done_b), .wr_drop_o(drop_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [3:0] mread(input logic [3:0][3:0] bank, input bit zr, input bit bp,
                                       input logic [1:0] a, input bit acc);
    logic [3:0] v;
    v = bank[a];
    if (bp && acc && rd == a) v = din;
    if (zr && a == 2'd0) v = 4'h0;
    return v;
  endfunction

  task automatic model_reset();
    m_a = '0;
    m_b = '0;
    m_busy = 1'b0;
    m_cnt = 2'd0;
    m_drop = 1'b0;
  endtask

  task automatic model_edge();
    bit acc_b, acc_a;
    acc_b = we && !m_busy && !clr;
    acc_a = acc_b && (rd != 2'd0);
    m_drop = we && (m_busy || clr);
    if (m_busy) begin
      m_a[m_cnt] = 4'h0;
      m_b[m_cnt] = 4'h0;
      if (m_cnt == 2'd3) begin
        m_busy = 1'b0;
        m_cnt = 2'd0;
      end else begin
        m_cnt = m_cnt + 2'd1;
      end
    end else begin
      if (clr) m_busy = 1'b1;
      if (acc_a) m_a[rd] = din;
      if (acc_b) m_b[rd] = din;
    end
  endtask

  task automatic check_now();
    logic [31:0] obs [10];
    bit acc_b, acc_a;
    acc_b = we && !m_busy && !clr;
    acc_a = acc_b && (rd != 2'd0);
    sb_q.push_back('{"a_rs1",  32'(mread(m_a, 1, 1, a1, acc_a))});
    sb_q.push_back('{"a_rs2",  32'(mread(m_a, 1, 1, a2, acc_a))});
    sb_q.push_back('{"a_busy", 32'(m_busy)});
    sb_q.push_back('{"a_done", 32'(m_busy && m_cnt == 2'd3)});
    sb_q.push_back('{"a_drop", 32'(m_drop)});
    sb_q.push_back('{"b_rs1",  32'(mread(m_b, 0, 0, a1, acc_b))});
    sb_q.push_back('{"b_rs2",  32'(mread(m_b, 0, 0, a2, acc_b))});
    sb_q.push_back('{"b_busy", 32'(m_busy)});
    sb_q.push_back('{"b_done", 32'(m_busy && m_cnt == 2'd3)});
    sb_q.push_back('{"b_drop", 32'(m_drop)});
    obs = '{32'(rs1_a), 32'(rs2_a), 32'(busy_a), 32'(done_a), 32'(drop_a),
            32'(rs1_b), 32'(rs2_b), 32'(busy_b), 32'(done_b), 32'(drop_b)};
    for (int k = 0; k < 10; k++) begin
      sb_t e;
      e = sb_q.pop_front();
      chk(e.tag, obs[k], e.exp);
    end
  endtask

  task automatic cycle(input logic c_we, input logic c_clr, input logic [1:0] c_a1,
                       input logic [1:0] c_a2, input logic [1:0] c_rd, input logic [3:0] c_d);
    @(negedge clk);
    we = c_we; clr = c_clr; a1 = c_a1; a2 = c_a2; rd = c_rd; din = c_d;
    #1;
    check_now();
    @(posedge clk);
    if (rst_n) model_edge();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_now();
    @(negedge clk);
    rst_n = 1'b1;

    // reset state on every address, both ports
    for (int i = 0; i < 4; i++) cycle(0, 0, 2'(i), 2'(3 - i), 0, 0);

    // write 0xA to r2: bypass instance forwards, plain instance shows old value
    cycle(1, 0, 2, 2, 2, 4'hA);
    cycle(0, 0, 2, 1, 0, 0);

    // write 0x5 to r3 with both ports on r3
    cycle(1, 0, 3, 3, 3, 4'h5);
    cycle(0, 0, 3, 3, 0, 0);

    // write 0xF to r0: ignored with zero register, stored otherwise
    cycle(1, 0, 0, 0, 0, 4'hF);
    cycle(0, 0, 0, 2, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);

    // load 1,2,3 then clear; writes during and alongside the clear are dropped
    cycle(1, 0, 1, 2, 1, 4'h1);
    cycle(1, 0, 1, 2, 2, 4'h2);
    cycle(1, 0, 3, 2, 3, 4'h3);
    cycle(1, 1, 1, 3, 2, 4'h9);
    cycle(1, 0, 1, 2, 1, 4'h7);
    cycle(0, 1, 2, 3, 0, 0);
    cycle(1, 0, 3, 1, 3, 4'hE);
    cycle(0, 0, 2, 3, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 2'(i), 2'(3 - i), 0, 0);

    // reset in the 2nd clear cycle aborts the clear and zeroes the bank
    cycle(1, 0, 1, 1, 1, 4'h4);
    cycle(1, 0, 2, 2, 2, 4'h9);
    cycle(1, 0, 3, 3, 3, 4'h6);
    cycle(0, 1, 2, 3, 0, 0);
    cycle(0, 0, 2, 3, 0, 0);
    @(negedge clk);
    we = 0; clr = 0; a1 = 2; a2 = 3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_now();
    @(negedge clk);
    a1 = 1; a2 = 0;
    #1;
    check_now();
    rst_n = 1'b1;
    cycle(1, 0, 2, 3, 1, 4'hC);
    cycle(0, 0, 1, 1, 0, 0);

    // random traffic
    for (int i = 0; i < 60; i++) begin
      cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
            2'($urandom), 2'($urandom), 2'($urandom), 4'($urandom));
    end
    for (int i = 0; i < 4; i++) cycle(0, 0, 2'(i), 2'(3 - i), 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
